// File: rtl/sha3_pkg.sv
// Shared definitions for the SHA3 block padder.
// Word and rate geometry, the pad10*1 marker bytes and the padder
// state encoding. Imported by pad_word_gen and keccak_block_padder.
package sha3_pkg;

  localparam int WORD_W     = 32;
  localparam int RATE_WORDS = 18;
  localparam int RATE_W     = WORD_W * RATE_WORDS;  // 576

  // pad10*1 markers: first pad byte follows the data, last pad byte ends the block
  localparam logic [7:0] PAD_FIRST = 8'h01;
  localparam logic [7:0] PAD_LAST  = 8'h80;

  typedef enum logic [1:0] {
    FILL = 2'd0,  // accepting message words
    PAD  = 2'd1,  // message ended, shifting in zero/terminal pad words
    FULL = 2'd2,  // block presented, waiting for f_ack
    DONE = 2'd3   // message fully handed over, parked until reset
  } padder_state_e;

endpackage

// File: rtl/pad_word_gen.sv
// Combinational generator for one padded 32-bit word.
// Ports:
//   in            : raw message word, first byte in [31:24]
//   byte_num      : number of valid data bytes when is_last (0..3)
//   is_last       : word carries the message end; data bytes beyond
//                   byte_num are cleared and PAD_FIRST inserted at byte_num
//   is_final_slot : word lands in the last slot of the block; OR PAD_LAST
//                   into the lowest byte
//   word          : resulting word
// The PAD state reuses this block with in=0 and is_last=0, yielding either
// 0x00000000 or 0x00000080.
module pad_word_gen
  import sha3_pkg::*;
(
  input  logic [WORD_W-1:0] in,
  input  logic [1:0]        byte_num,
  input  logic              is_last,
  input  logic              is_final_slot,
  output logic [WORD_W-1:0] word
);

  logic [WORD_W-1:0] base;

  always_comb begin
    base = in;
    if (is_last) begin
      // byte i sits at bits [31-8i -: 8]; byte_num <= 3 so PAD_FIRST always fits
      for (int i = 0; i < 4; i++) begin
        if (i < int'(byte_num)) begin
          base[31-8*i -: 8] = in[31-8*i -: 8];
        end else if (i == int'(byte_num)) begin
          base[31-8*i -: 8] = PAD_FIRST;
        end else begin
          base[31-8*i -: 8] = 8'h00;
        end
      end
    end
    word = base;
    if (is_final_slot) begin
      word[7:0] = base[7:0] | PAD_LAST;
    end
  end

endmodule

// File: rtl/keccak_block_padder.sv
// Collects 32-bit message words into 576-bit rate blocks, applies Keccak
// pad10*1 and hands each block to the permutation core.
// Ports:
//   clk, reset : clock, synchronous active-high reset
//   in         : message word (first byte in [31:24])
//   in_valid   : in carries a word this cycle
//   is_last    : current word ends the message (qualified by in_valid)
//   byte_num   : valid bytes in the last word, 0..3 (qualified by is_last)
//   in_busy    : high when a word would not be accepted this cycle
//   out        : rate block, word 0 at [575:544], word 17 at [31:0]
//   out_ready  : block valid, held until f_ack
//   f_ack      : core consumed the block (only honoured while out_ready)
//   dbg_state  : current FSM state, for observation only
// Handshake: a word transfers on any rising edge where in_valid=1 and
// in_busy=0; a block transfers on any rising edge where out_ready=1 and
// f_ack=1. Both in_busy and out_ready come straight from the state register.
module keccak_block_padder
  import sha3_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [WORD_W-1:0] in,
  input  logic              in_valid,
  input  logic              is_last,
  input  logic [1:0]        byte_num,
  output logic              in_busy,
  output logic [RATE_W-1:0] out,
  output logic              out_ready,
  input  logic              f_ack,
  output padder_state_e     dbg_state
);

  localparam logic [4:0] LAST_SLOT = 5'(RATE_WORDS - 1);

  padder_state_e     state_q, state_d;
  logic [4:0]        count_q, count_d;
  logic [RATE_W-1:0] out_q, out_d;
  logic              has_end_q, has_end_d;  // current block contains the message end

  logic [WORD_W-1:0] gen_in;
  logic              gen_last;
  logic              gen_final;
  logic [WORD_W-1:0] pad_word;

  // In PAD the generator sees a zero word, so it produces 0 or PAD_LAST only.
  assign gen_in    = (state_q == PAD) ? '0 : in;
  assign gen_last  = (state_q == FILL) && is_last;
  assign gen_final = (count_q == LAST_SLOT) && ((state_q == PAD) || gen_last);

  pad_word_gen u_pad_word_gen (
    .in            (gen_in),
    .byte_num      (byte_num),
    .is_last       (gen_last),
    .is_final_slot (gen_final),
    .word          (pad_word)
  );

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    out_d     = out_q;
    has_end_d = has_end_q;
    case (state_q)
      FILL: begin
        if (in_valid) begin
          out_d   = {out_q[RATE_W-WORD_W-1:0], pad_word};
          count_d = count_q + 5'd1;
          if (is_last) begin
            has_end_d = 1'b1;
            state_d   = (count_q == LAST_SLOT) ? FULL : PAD;
          end else if (count_q == LAST_SLOT) begin
            state_d = FULL;
          end
        end
      end
      PAD: begin
        out_d   = {out_q[RATE_W-WORD_W-1:0], pad_word};
        count_d = count_q + 5'd1;
        if (count_q == LAST_SLOT) begin
          state_d = FULL;
        end
      end
      FULL: begin
        // out is left intact; the next block overwrites it by shifting
        if (f_ack) begin
          count_d   = 5'd0;
          has_end_d = 1'b0;
          state_d   = has_end_q ? DONE : FILL;
        end
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = FILL;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= FILL;
      count_q   <= 5'd0;
      out_q     <= '0;
      has_end_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      out_q     <= out_d;
      has_end_q <= has_end_d;
    end
  end

  assign in_busy   = (state_q != FILL);
  assign out_ready = (state_q == FULL);
  assign out       = out_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_keccak_block_padder.sv
module tb_keccak_block_padder;
  import sha3_pkg::*;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   in;
  logic          in_valid;
  logic          is_last;
  logic [1:0]    byte_num;
  logic          in_busy;
  logic [575:0]  out;
  logic          out_ready;
  logic          f_ack;
  padder_state_e dbg_state;

  always #5 clk = ~clk;

  keccak_block_padder dut (
    .clk       (clk),
    .reset     (reset),
    .in        (in),
    .in_valid  (in_valid),
    .is_last   (is_last),
    .byte_num  (byte_num),
    .in_busy   (in_busy),
    .out       (out),
    .out_ready (out_ready),
    .f_ack     (f_ack),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int tests = 0;
  int fails = 0;
  logic [575:0] exp_q[$];

  typedef struct {
    logic [31:0] d_in;
    logic [1:0]  bn;
    logic [31:0] exp_w0;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [575:0] act, input logic [575:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0; is_last = 1'b0; byte_num = 2'd0; in = '0; f_ack = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Presents a word and returns just after the edge that accepted it.
  task automatic send_word(input logic [31:0] w, input logic last, input logic [1:0] bn);
    int guard;
    guard = 0;
    @(negedge clk);
    in = w; is_last = last; byte_num = bn; in_valid = 1'b1;
    while (in_busy && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (in_busy) begin
      tests++; fails++;
      $display("FAIL send_word: in_busy stuck at %0b, required 0", in_busy);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0; is_last = 1'b0;
  endtask

  // Waits for out_ready, counting negedges after the current edge, then
  // compares the block against the scoreboard head.
  task automatic wait_block(output int cycles);
    cycles = 0;
    @(negedge clk);
    while (!out_ready && cycles < 60) begin
      @(negedge clk);
      cycles++;
    end
    if (!out_ready) begin
      tests++; fails++;
      $display("FAIL wait_block: out_ready %0b after %0d cycles, required 1", out_ready, cycles);
    end else if (exp_q.size() == 0) begin
      tests++; fails++;
      $display("FAIL scoreboard: block seen %h, required none pending", out);
    end else begin
      check("block", out, exp_q.pop_front());
    end
  endtask

  task automatic ack();
    @(negedge clk);
    f_ack = 1'b1;
    @(negedge clk);
    f_ack = 1'b0;
  endtask

  task automatic check_done(input string name);
    check({name, "_out_ready"}, 576'(out_ready), 576'(1'b0));
    check({name, "_in_busy"}, 576'(in_busy), 576'(1'b1));
    check({name, "_state"}, 576'(dbg_state), 576'(DONE));
  endtask

  // ---------------- test ----------------
  logic [575:0] blk1, blk2;
  int cyc;

  initial begin
    vecs[0] = '{32'hDEADBEEF, 2'd0, 32'h01000000};
    vecs[1] = '{32'hAABBCCDD, 2'd1, 32'hAA010000};
    vecs[2] = '{32'hAABBCCDD, 2'd2, 32'hAABB0100};
    vecs[3] = '{32'h11223344, 2'd3, 32'h11223301};
    vecs[4] = '{32'hFFFFFFFF, 2'd3, 32'hFFFFFF01};
    vecs[5] = '{32'h00000000, 2'd2, 32'h00000100};

    reset = 1'b1; in = '0; in_valid = 1'b0; is_last = 1'b0; byte_num = 2'd0; f_ack = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out", out, '0);
    check("rst_out_ready", 576'(out_ready), 576'(1'b0));
    check("rst_in_busy", 576'(in_busy), 576'(1'b0));
    check("rst_state", 576'(dbg_state), 576'(FILL));
    reset = 1'b0;

    // Single-word messages: one padded word, 16 zero words, terminal 0x80.
    for (int v = 0; v < 6; v++) begin
      do_reset();
      exp_q.push_back({vecs[v].exp_w0, 512'd0, 32'h00000080});
      send_word(vecs[v].d_in, 1'b1, vecs[v].bn);
      wait_block(cyc);
      check("latency_18_edges", 576'(cyc), 576'(17));
      ack();
      check_done("vec_done");
    end

    // Full 18-word block, held under back-pressure, then a 2-byte final word.
    do_reset();
    blk1 = '0;
    for (int i = 0; i < 18; i++) blk1[575-32*i -: 32] = 32'(i);
    exp_q.push_back(blk1);
    for (int i = 0; i < 18; i++) send_word(32'(i), 1'b0, 2'd0);
    wait_block(cyc);
    check("full_latency", 576'(cyc), 576'(0));
    in = 32'hAABBCCDD; is_last = 1'b1; byte_num = 2'd2; in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("hold_out", out, blk1);
      check("hold_out_ready", 576'(out_ready), 576'(1'b1));
      check("hold_in_busy", 576'(in_busy), 576'(1'b1));
    end
    f_ack = 1'b1;
    @(negedge clk);
    f_ack = 1'b0;
    check("ack_out_ready_fall", 576'(out_ready), 576'(1'b0));
    check("ack_in_busy", 576'(in_busy), 576'(1'b0));
    check("ack_not_cleared", out, blk1);
    @(posedge clk);
    #1;
    in_valid = 1'b0; is_last = 1'b0;
    exp_q.push_back({32'hAABB0100, 512'd0, 32'h00000080});
    wait_block(cyc);
    check("block2_latency", 576'(cyc), 576'(17));
    ack();
    check_done("block2_done");

    // Message end in slot 17: no PAD cycles, 0x80 merged into the last word.
    do_reset();
    blk2 = '0;
    for (int i = 0; i < 17; i++) blk2[575-32*i -: 32] = 32'h100 + 32'(i);
    blk2[31:0] = 32'h11223381;
    exp_q.push_back(blk2);
    for (int i = 0; i < 17; i++) send_word(32'h100 + 32'(i), 1'b0, 2'd0);
    send_word(32'h11223344, 1'b1, 2'd3);
    wait_block(cyc);
    check("slot17_no_pad", 576'(cyc), 576'(0));
    ack();
    check_done("slot17_done");

    // DONE ignores words and f_ack.
    in_valid = 1'b1; is_last = 1'b0;
    for (int k = 0; k < 10; k++) begin
      in = $urandom;
      f_ack = k[0];
      @(negedge clk);
      check("done_in_busy", 576'(in_busy), 576'(1'b1));
      check("done_out_ready", 576'(out_ready), 576'(1'b0));
      check("done_out", out, blk2);
    end
    in_valid = 1'b0; f_ack = 1'b0;

    // Reset in the middle of a block discards it.
    do_reset();
    for (int i = 0; i < 7; i++) send_word(32'($urandom_range(1, 32'hFFFF_FFFE)), 1'b0, 2'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_out", out, '0);
    check("midrst_out_ready", 576'(out_ready), 576'(1'b0));
    check("midrst_in_busy", 576'(in_busy), 576'(1'b0));
    exp_q.push_back({32'h01000000, 512'd0, 32'h00000080});
    send_word(32'hDEADBEEF, 1'b1, 2'd0);
    wait_block(cyc);
    check("midrst_latency", 576'(cyc), 576'(17));

    check("scoreboard_empty", 576'(exp_q.size()), 576'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
